// File: rtl/spi_peripheral.sv
// SPI responder for single/dual/quad links: oversamples cs_n/sclk/data in the clk domain.
// Optional build macro SPI_PERIPHERAL_BYTE_COUNT_EN adds a saturating received-byte counter.
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic [3:0]  spi_data_in,
  output logic [3:0]  spi_data_out,
  output logic [3:0]  spi_data_oe,
  input  logic [2:0]  spi_mode_in,
  input  logic        spi_dir_out,
  input  logic [7:0]  spi_byte_tx,
  output logic        spi_tx_load,
  output logic [7:0]  spi_byte_rx,
  output logic        spi_rx_strobe,
  output logic        spi_selected
`ifdef SPI_PERIPHERAL_BYTE_COUNT_EN
  ,
  output logic [15:0] spi_byte_count
`endif
);

  typedef enum logic {IDLE, SELECT} state_t;

  state_t                       state;
  logic [SYNC_STAGES-1:0]       cs_sync, sclk_sync;
  logic [SYNC_STAGES-1:0][3:0]  d_sync;
  logic                         cs_prev, sclk_prev;
  logic [2:0]                   bits, width, bits_next;
  logic [7:0]                   rx_shift, tx_shift, rx_next;
  logic                         seen_rise;

  wire       cs_s      = cs_sync[SYNC_STAGES-1];
  wire       sclk_s    = sclk_sync[SYNC_STAGES-1];
  wire [3:0] d_s       = d_sync[SYNC_STAGES-1];
  wire       cs_fall   = cs_prev & ~cs_s;
  wire       cs_rise   = ~cs_prev & cs_s;
  wire       sclk_rise = ~sclk_prev & sclk_s;
  wire       sclk_fall = sclk_prev & ~sclk_s;

  function automatic logic [2:0] decode_mode(input logic [2:0] m);
    case (m)
      3'd2:    decode_mode = 3'd2;
      3'd4:    decode_mode = 3'd4;
      default: decode_mode = 3'd1;
    endcase
  endfunction

  // The cs chain resets to "selected" so a cs_n already low at reset release is not seen as a fresh fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      d_sync    <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      d_sync    <= {d_sync[SYNC_STAGES-2:0], spi_data_in};
    end
  end

  always_comb begin
    bits_next = bits + width;
    case (width)
      3'd2:    rx_next = {rx_shift[5:0], d_s[1:0]};
      3'd4:    rx_next = {rx_shift[3:0], d_s};
      default: rx_next = {rx_shift[6:0], d_s[0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cs_prev       <= 1'b0;
      sclk_prev     <= 1'b0;
      bits          <= '0;
      width         <= 3'd1;
      rx_shift      <= '0;
      tx_shift      <= '0;
      seen_rise     <= 1'b0;
      spi_byte_rx   <= '0;
      spi_rx_strobe <= 1'b0;
      spi_tx_load   <= 1'b0;
      spi_selected  <= 1'b0;
    end else begin
      cs_prev       <= cs_s;
      sclk_prev     <= sclk_s;
      spi_rx_strobe <= 1'b0;
      spi_tx_load   <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          state        <= SELECT;
          spi_selected <= 1'b1;
          bits         <= '0;
          width        <= decode_mode(spi_mode_in);
          rx_shift     <= '0;
          tx_shift     <= spi_byte_tx;
          spi_tx_load  <= 1'b1;
          seen_rise    <= 1'b0;
        end
        SELECT: begin
          if (sclk_rise) begin
            rx_shift  <= rx_next;
            bits      <= bits_next;
            seen_rise <= 1'b1;
            if (bits_next == 3'd0) begin
              spi_byte_rx   <= rx_next;
              spi_rx_strobe <= 1'b1;
              width         <= decode_mode(spi_mode_in);
            end
          end else if (sclk_fall && seen_rise && !cs_rise) begin
            if (bits == 3'd0) begin
              tx_shift    <= spi_byte_tx;
              spi_tx_load <= 1'b1;
            end else begin
              tx_shift <= tx_shift << width;
            end
          end
          // A completing rising edge in the same cycle still strobes before we drop out.
          if (cs_rise) begin
            state        <= IDLE;
            spi_selected <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    spi_data_out = '0;
    spi_data_oe  = '0;
    if (state == SELECT) begin
      case (width)
        3'd2: begin
          spi_data_out[1:0] = tx_shift[7:6];
          spi_data_oe       = spi_dir_out ? 4'b0011 : 4'b0000;
        end
        3'd4: begin
          spi_data_out = tx_shift[7:4];
          spi_data_oe  = spi_dir_out ? 4'b1111 : 4'b0000;
        end
        default: begin
          spi_data_out[1] = tx_shift[7];
          spi_data_oe     = 4'b0010;
        end
      endcase
    end
  end

`ifdef SPI_PERIPHERAL_BYTE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      spi_byte_count <= '0;
    else if (state == IDLE && cs_fall)
      spi_byte_count <= '0;
    else if (spi_rx_strobe && spi_byte_count != 16'hFFFF)
      spi_byte_count <= spi_byte_count + 16'd1;
  end
`endif

endmodule
